// File: rtl/pattern_seq_ctrl_pkg.sv
// rtl/pattern_seq_ctrl_pkg.sv - shared constants and FSM encoding for the pattern sequencer
//
// Purpose : pattern index names understood by the generator, default sizing and
//           the scheduler state encoding.
// Ports   : none (package).
package pattern_seq_ctrl_pkg;

    localparam int unsigned DEF_NUM_PAT  = 8;
    localparam int unsigned DEF_PAT_BITS = 3;

    // Pattern indices decoded by the generator
    localparam int unsigned PAT_GRAY     = 0;
    localparam int unsigned PAT_WHITE    = 1;
    localparam int unsigned PAT_COLORBAR = 2;
    localparam int unsigned PAT_BLACK    = 3;
    localparam int unsigned PAT_RED      = 4;
    localparam int unsigned PAT_GREEN    = 5;
    localparam int unsigned PAT_BLUE     = 6;
    localparam int unsigned PAT_RAMP     = 7;

    typedef enum logic {
        ST_WAIT_SYNC = 1'b0,
        ST_RUN       = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pattern_seq_ctrl_vsync_edge_det.sv
// rtl/pattern_seq_ctrl_vsync_edge_det.sv - vsync active-edge detector
//
// Purpose : flags the cycle in which vs_in first shows its active level.
// Ports   : pix_clk  - pixel clock
//           rstn     - asynchronous active-low reset
//           vs_in    - vsync from the timing generator
//           act_edge - high while vs_in is active and was inactive last cycle
module pattern_seq_ctrl_vsync_edge_det #(
    parameter logic VS_POL = 1'b1
) (
    input  logic pix_clk,
    input  logic rstn,
    input  logic vs_in,
    output logic act_edge
);

    logic vs_d_q;

    // Reset to the active level so a vsync already asserted when reset
    // releases is not mistaken for a fresh frame start.
    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            vs_d_q <= VS_POL;
        end else begin
            vs_d_q <= vs_in;
        end
    end

    assign act_edge = (vs_in == VS_POL) && (vs_d_q != VS_POL);

endmodule

// File: rtl/pattern_seq_ctrl.sv
// rtl/pattern_seq_ctrl.sv - frame-synchronous test-pattern scheduler
//
// Purpose : selects the generator pattern, changing it only at frame start.
//           Auto mode advances every FRAMES_PER_PAT frames; host mode holds a
//           pattern written through a one-deep valid/ready shadow register.
// Ports   : pix_clk, rstn              - clock, async active-low reset
//           vs_in, de_in               - timing stream (de_in is not used by logic)
//           cfg_valid/cfg_ready        - host handshake, cfg_pat/cfg_auto payload
//           pat_sel, auto_mode         - current pattern and mode
//           frame_start, sync_lost     - one-cycle event pulses
//           frame_cnt                  - frames since sync acquired
//           locked                     - high while running synchronised
module pattern_seq_ctrl
    import pattern_seq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PAT        = DEF_NUM_PAT,
    parameter int unsigned PAT_BITS       = DEF_PAT_BITS,
    parameter int unsigned FRAMES_PER_PAT = 60,
    parameter logic        VS_POL         = 1'b1,
    parameter logic [23:0] TIMEOUT        = 24'd2_000_000
) (
    input  logic                pix_clk,
    input  logic                rstn,
    input  logic                vs_in,
    input  logic                de_in,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PAT_BITS-1:0] cfg_pat,
    input  logic                cfg_auto,
    output logic [PAT_BITS-1:0] pat_sel,
    output logic                auto_mode,
    output logic                frame_start,
    output logic [15:0]         frame_cnt,
    output logic                sync_lost,
    output logic                locked
);

    localparam int unsigned DW = $clog2(FRAMES_PER_PAT) + 1;
    localparam logic [DW-1:0]       DWELL_LAST = DW'(FRAMES_PER_PAT - 1);
    localparam logic [PAT_BITS-1:0] PAT_LAST   = PAT_BITS'(NUM_PAT - 1);
    // One bit wider so NUM_PAT == 2**PAT_BITS does not truncate to zero
    localparam logic [PAT_BITS:0]   NUM_PAT_W  = (PAT_BITS + 1)'(NUM_PAT);

    seq_state_e          state_q, state_d;
    logic [PAT_BITS-1:0] pat_q, pat_d;
    logic                auto_q, auto_d;
    logic                fs_q, fs_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                lost_q, lost_d;
    logic                sh_full_q, sh_full_d;
    logic [PAT_BITS-1:0] sh_pat_q, sh_pat_d;
    logic                sh_auto_q, sh_auto_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [23:0]         wdog_q, wdog_d;
    logic                act_edge;
    logic [PAT_BITS-1:0] cfg_pat_clamped;
    logic                de_unused;

    // de_in is only observed by external timing checks
    assign de_unused = de_in;

    pattern_seq_ctrl_vsync_edge_det #(
        .VS_POL (VS_POL)
    ) u_edge_det (
        .pix_clk  (pix_clk),
        .rstn     (rstn),
        .vs_in    (vs_in),
        .act_edge (act_edge)
    );

    assign cfg_pat_clamped = ({1'b0, cfg_pat} >= NUM_PAT_W) ? PAT_LAST : cfg_pat;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        auto_d    = auto_q;
        fs_d      = 1'b0;
        cnt_d     = cnt_q;
        lost_d    = 1'b0;
        sh_full_d = sh_full_q;
        sh_pat_d  = sh_pat_q;
        sh_auto_d = sh_auto_q;
        dwell_d   = dwell_q;
        wdog_d    = wdog_q;

        case (state_q)
            ST_WAIT_SYNC: begin
                if (act_edge) begin
                    state_d = ST_RUN;
                    fs_d    = 1'b1;
                    cnt_d   = 16'd0;
                    dwell_d = '0;
                    wdog_d  = 24'd0;
                    if (sh_full_q) begin
                        pat_d     = sh_pat_q;
                        auto_d    = sh_auto_q;
                        sh_full_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (act_edge) begin
                    fs_d   = 1'b1;
                    cnt_d  = cnt_q + 16'd1;
                    wdog_d = 24'd0;
                    // A pending host request wins over the auto advance
                    if (sh_full_q) begin
                        pat_d     = sh_pat_q;
                        auto_d    = sh_auto_q;
                        sh_full_d = 1'b0;
                        dwell_d   = '0;
                    end else if (auto_q && (dwell_q == DWELL_LAST)) begin
                        dwell_d = '0;
                        pat_d   = (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;
                    end else if (auto_q) begin
                        dwell_d = dwell_q + 1'b1;
                    end else begin
                        dwell_d = '0;
                    end
                end else if (wdog_q == TIMEOUT - 24'd1) begin
                    lost_d  = 1'b1;
                    state_d = ST_WAIT_SYNC;
                    wdog_d  = 24'd0;
                end else begin
                    wdog_d = wdog_q + 24'd1;
                end
            end
        endcase

        // Acceptance only happens with the shadow empty, so it never collides
        // with the frame-start application above, which needs it full.
        if (cfg_valid && !sh_full_q) begin
            sh_full_d = 1'b1;
            sh_pat_d  = cfg_pat_clamped;
            sh_auto_d = cfg_auto;
        end
    end

    always_ff @(posedge pix_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_WAIT_SYNC;
            pat_q     <= PAT_BITS'(PAT_GRAY);
            auto_q    <= 1'b1;
            fs_q      <= 1'b0;
            cnt_q     <= 16'd0;
            lost_q    <= 1'b0;
            sh_full_q <= 1'b0;
            sh_pat_q  <= '0;
            sh_auto_q <= 1'b0;
            dwell_q   <= '0;
            wdog_q    <= 24'd0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            auto_q    <= auto_d;
            fs_q      <= fs_d;
            cnt_q     <= cnt_d;
            lost_q    <= lost_d;
            sh_full_q <= sh_full_d;
            sh_pat_q  <= sh_pat_d;
            sh_auto_q <= sh_auto_d;
            dwell_q   <= dwell_d;
            wdog_q    <= wdog_d;
        end
    end

    assign cfg_ready   = !sh_full_q;
    assign pat_sel     = pat_q;
    assign auto_mode   = auto_q;
    assign frame_start = fs_q;
    assign frame_cnt   = cnt_q;
    assign sync_lost   = lost_q;
    assign locked      = (state_q == ST_RUN);

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb/tb_pattern_seq_ctrl.sv - scoreboard bench for pattern_seq_ctrl
module tb_pattern_seq_ctrl;

    localparam int NP  = 4;
    localparam int PB  = 3;
    localparam int FPP = 2;
    localparam int TO  = 150;

    logic          pix_clk = 1'b0;
    logic          rstn;
    logic          vs_in, de_in, cfg_valid, cfg_auto;
    logic [PB-1:0] cfg_pat;
    logic          cfg_ready, auto_mode, frame_start, sync_lost, locked;
    logic [PB-1:0] pat_sel;
    logic [15:0]   frame_cnt;

    pattern_seq_ctrl #(
        .NUM_PAT        (NP),
        .PAT_BITS       (PB),
        .FRAMES_PER_PAT (FPP),
        .VS_POL         (1'b1),
        .TIMEOUT        (24'(TO))
    ) dut (
        .pix_clk     (pix_clk),
        .rstn        (rstn),
        .vs_in       (vs_in),
        .de_in       (de_in),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pat     (cfg_pat),
        .cfg_auto    (cfg_auto),
        .pat_sel     (pat_sel),
        .auto_mode   (auto_mode),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .sync_lost   (sync_lost),
        .locked      (locked)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct {
        bit lost;
        int pat;
        bit auto_m;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Frame-level reference model
    int m_pat, m_cnt, m_dwell, m_idle, m_sh_pat;
    bit m_auto, m_locked, m_sh_full, m_sh_auto, m_prev_vs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pat = 0; m_cnt = 0; m_dwell = 0; m_idle = 0; m_sh_pat = 0;
        m_auto = 1'b1; m_locked = 1'b0; m_sh_full = 1'b0; m_sh_auto = 1'b0;
        m_prev_vs = 1'b0;
        q.delete();
    endfunction

    function automatic void model_clock();
        bit   act, xfer;
        exp_t e;
        act       = vs_in && !m_prev_vs;
        m_prev_vs = vs_in;
        xfer      = cfg_valid && !m_sh_full;
        if (act) begin
            if (!m_locked) begin
                m_locked = 1'b1;
                m_cnt    = 0;
                m_dwell  = 0;
                if (m_sh_full) begin
                    m_pat = m_sh_pat; m_auto = m_sh_auto; m_sh_full = 1'b0;
                end
            end else begin
                m_cnt = (m_cnt + 1) % 65536;
                if (m_sh_full) begin
                    m_pat = m_sh_pat; m_auto = m_sh_auto; m_sh_full = 1'b0; m_dwell = 0;
                end else if (m_auto) begin
                    m_dwell++;
                    if (m_dwell == FPP) begin
                        m_dwell = 0;
                        m_pat   = (m_pat + 1) % NP;
                    end
                end
            end
            m_idle = 0;
            e.lost = 1'b0; e.pat = m_pat; e.auto_m = m_auto; e.cnt = m_cnt;
            q.push_back(e);
        end else if (m_locked) begin
            if (m_idle == TO - 1) begin
                m_locked = 1'b0;
                e.lost = 1'b1; e.pat = m_pat; e.auto_m = m_auto; e.cnt = m_cnt;
                q.push_back(e);
            end else begin
                m_idle++;
            end
        end
        if (xfer) begin
            m_sh_full = 1'b1;
            m_sh_pat  = (int'(cfg_pat) >= NP) ? NP - 1 : int'(cfg_pat);
            m_sh_auto = cfg_auto;
        end
    endfunction

    task automatic step(input logic vs, input logic de, input logic cv,
                        input logic [PB-1:0] cp, input logic ca);
        @(negedge pix_clk);
        vs_in = vs; de_in = de; cfg_valid = cv; cfg_pat = cp; cfg_auto = ca;
        @(posedge pix_clk);
        model_clock();
    endtask

    task automatic frame(input int len, input int cfg_at, input logic [PB-1:0] cp, input logic ca);
        for (int i = 0; i < len; i++) begin
            step(i < 3, (i >= 6) && (i < len - 3), i == cfg_at, cp, ca);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: pops an expectation for each event pulse the DUT presents
    logic [PB-1:0] last_pat;
    always @(negedge pix_clk) begin
        if (rstn !== 1'b1) begin
            last_pat = pat_sel;
        end else begin
            if (frame_start === 1'b1 || sync_lost === 1'b1) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_pulse: got fs=%0b lost=%0b expected none at %0t",
                             frame_start, sync_lost, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_is_lost", 32'(sync_lost), 32'(e.lost));
                    chk("pulse_is_fs", 32'(frame_start), 32'(!e.lost));
                    chk("pat_sel", 32'(pat_sel), 32'(e.pat));
                    chk("auto_mode", 32'(auto_mode), 32'(e.auto_m));
                    chk("locked", 32'(locked), 32'(!e.lost));
                    if (!e.lost) chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                end
            end else begin
                chk("pat_hold", 32'(pat_sel), 32'(last_pat));
            end
            if (q.size() != 0) begin
                n_tests++; n_fail++;
                $display("FAIL missing_pulse: got no pulse expected %0d event(s) at %0t", q.size(), $time);
                q.delete();
            end
            chk("cfg_ready", 32'(cfg_ready), 32'(!m_sh_full));
            last_pat = pat_sel;
        end
    end

    // Stimulus must never raise de together with the vsync active edge
    logic tb_prev_vs = 1'b0;
    always @(posedge pix_clk) begin
        assert (!(rstn === 1'b1 && vs_in && !tb_prev_vs && de_in))
            else $error("de_in high at vsync edge");
        tb_prev_vs <= vs_in;
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_pat_sel"}, 32'(pat_sel), 32'd0);
        chk({tag, "_auto_mode"}, 32'(auto_mode), 32'd1);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_sync_lost"}, 32'(sync_lost), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        rstn = 1'b0; vs_in = 1'b0; de_in = 1'b0; cfg_valid = 1'b0; cfg_pat = '0; cfg_auto = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge pix_clk);
        rstn = 1'b1;
        idle(4);

        // Auto cycling: first edge acquires sync, then advance every FPP frames
        for (int f = 0; f < 5; f++) frame(30, -1, '0, 1'b0);
        @(negedge pix_clk);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd4);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_pat_sel", 32'(pat_sel), 32'd2);
        for (int f = 0; f < 5; f++) frame(30, -1, '0, 1'b0);

        // Host request mid-frame, then a clamped request on the edge cycle
        frame(40, 15, 3'd2, 1'b0);
        for (int f = 0; f < 3; f++) frame(40, -1, '0, 1'b0);
        frame(40, 0, 3'd7, 1'b0);
        for (int f = 0; f < 2; f++) frame(40, -1, '0, 1'b0);
        frame(30, 10, 3'd1, 1'b1);
        for (int f = 0; f < 4; f++) frame(30, -1, '0, 1'b0);

        // Lose sync, then relock
        idle(TO + 30);
        for (int f = 0; f < 3; f++) frame(30, -1, '0, 1'b0);

        // Randomised frames, requests and gaps around the timeout boundary
        for (int f = 0; f < 60; f++) begin
            int len, at;
            len = $urandom_range(20, 60);
            at  = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, len - 1);
            frame(len, at, PB'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(TO - 40, TO + 10));
        end

        // Async reset mid-frame with a request pending
        frame(30, -1, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge pix_clk);
        vs_in = 1'b0; de_in = 1'b1; cfg_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        de_in = 1'b0;
        repeat (2) @(posedge pix_clk);
        @(negedge pix_clk);
        rstn = 1'b1;
        idle(3);
        for (int f = 0; f < 3; f++) frame(30, -1, '0, 1'b0);
        idle(2);

        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL leftover_events: got %0d unmatched expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
